// File: rtl/i2c_bus_monitor_if.sv
// rtl/i2c_bus_monitor_if.sv - bus levels, control strobes and status flags of the I2C bus monitor
interface i2c_bus_monitor_if #(
  parameter int PRESCALE_W = 16,
  parameter int TOUT_W     = 20
);
  logic [PRESCALE_W-1:0] prescale;
  logic [TOUT_W-1:0]     timeout_limit;
  logic                  scl_in;
  logic                  sda_in;
  logic                  sda_oe;
  logic                  master_active;
  logic                  arb_lost_clr;
  logic                  timeout_clr;
  logic                  filter_tick;
  logic                  start_det;
  logic                  rep_start_det;
  logic                  stop_det;
  logic                  bus_busy;
  logic                  bus_free;
  logic                  arb_lost;
  logic                  scl_timeout;

  modport master (
    output prescale, timeout_limit, scl_in, sda_in, sda_oe, master_active,
           arb_lost_clr, timeout_clr,
    input  filter_tick, start_det, rep_start_det, stop_det, bus_busy, bus_free,
           arb_lost, scl_timeout
  );

  modport slave (
    input  prescale, timeout_limit, scl_in, sda_in, sda_oe, master_active,
           arb_lost_clr, timeout_clr,
    output filter_tick, start_det, rep_start_det, stop_det, bus_busy, bus_free,
           arb_lost, scl_timeout
  );
endinterface

// File: rtl/i2c_bus_monitor.sv
// rtl/i2c_bus_monitor.sv - I2C bus state tracker: START/STOP detection, tBUF, SCL-low timeout, arbitration loss
module i2c_bus_monitor #(
  parameter int PRESCALE_W = 16,
  parameter int TBUF_TICKS = 8,
  parameter int TOUT_W     = 20
) (
  input  logic             clk_sync,
  input  logic             reset_n,
  i2c_bus_monitor_if.slave bus_if
);
  localparam int TBUF_W = $clog2(TBUF_TICKS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_FREE_WAIT
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PRESCALE_W-1:0] r_presc_cnt;
  logic                  r_tick;
  logic                  w_tick;
  logic                  r_scl_q;
  logic                  r_sda_q;
  logic                  r_primed;
  logic [TBUF_W-1:0]     r_tbuf_cnt;
  logic [TBUF_W-1:0]     w_tbuf_nxt;
  logic [TOUT_W-1:0]     r_low_cnt;
  logic                  r_start_det;
  logic                  r_rep_start_det;
  logic                  r_stop_det;
  logic                  r_bus_busy;
  logic                  r_bus_free;
  logic                  r_arb_lost;
  logic                  r_scl_timeout;
  logic                  w_start;
  logic                  w_stop;
  logic                  w_scl_rise;
  logic                  w_timeout;
  logic                  w_arb_set;
  logic                  w_start_nxt;
  logic                  w_rep_nxt;
  logic                  w_stop_nxt;
  logic                  w_tout_set;

  // Compare with >= so a prescale reduced below the running count fires on the next edge.
  assign w_tick = (r_presc_cnt >= bus_if.prescale);

  always_ff @(posedge clk_sync or negedge reset_n) begin
    if (!reset_n) begin
      r_presc_cnt <= '0;
      r_tick      <= 1'b0;
    end else begin
      r_tick      <= w_tick;
      r_presc_cnt <= w_tick ? '0 : r_presc_cnt + 1'b1;
    end
  end

  // r_primed masks the first cycle after reset so a bus held with SDA low is not seen as START.
  always_ff @(posedge clk_sync or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_q  <= 1'b1;
      r_sda_q  <= 1'b1;
      r_primed <= 1'b0;
    end else begin
      r_scl_q  <= bus_if.scl_in;
      r_sda_q  <= bus_if.sda_in;
      r_primed <= 1'b1;
    end
  end

  assign w_start    = r_primed & r_scl_q & bus_if.scl_in & r_sda_q & ~bus_if.sda_in;
  assign w_stop     = r_primed & r_scl_q & bus_if.scl_in & ~r_sda_q & bus_if.sda_in;
  assign w_scl_rise = r_primed & ~r_scl_q & bus_if.scl_in;
  assign w_timeout  = (r_state == ST_BUSY) && (bus_if.timeout_limit != '0) &&
                      (r_low_cnt >= bus_if.timeout_limit);

  always_ff @(posedge clk_sync or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_tbuf_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tbuf_cnt <= w_tbuf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tbuf_nxt  = r_tbuf_cnt;
    w_start_nxt = 1'b0;
    w_rep_nxt   = 1'b0;
    w_stop_nxt  = 1'b0;
    w_tout_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tbuf_nxt = '0;
        if (w_start) begin
          w_start_nxt = 1'b1;
          w_state_nxt = ST_BUSY;
        end else if (w_stop) begin
          w_stop_nxt = 1'b1;
        end
      end
      ST_BUSY: begin
        w_tbuf_nxt = '0;
        if (w_timeout) begin
          w_tout_set  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_start) begin
          w_start_nxt = 1'b1;
          w_rep_nxt   = 1'b1;
        end else if (w_stop) begin
          w_stop_nxt  = 1'b1;
          w_state_nxt = ST_FREE_WAIT;
        end
      end
      ST_FREE_WAIT: begin
        if (w_start) begin
          w_start_nxt = 1'b1;
          w_tbuf_nxt  = '0;
          w_state_nxt = ST_BUSY;
        end else if (w_stop) begin
          w_stop_nxt = 1'b1;
          w_tbuf_nxt = '0;
        end else if (r_tick) begin
          if (r_tbuf_cnt >= TBUF_W'(TBUF_TICKS - 1)) begin
            w_tbuf_nxt  = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_tbuf_nxt = r_tbuf_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_tbuf_nxt  = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Saturating SCL-low counter, held at zero whenever SCL is high or the bus is not BUSY.
  always_ff @(posedge clk_sync or negedge reset_n) begin
    if (!reset_n) begin
      r_low_cnt <= '0;
    end else if ((w_state_nxt != ST_BUSY) || bus_if.scl_in) begin
      r_low_cnt <= '0;
    end else if (r_tick && (r_low_cnt != '1)) begin
      r_low_cnt <= r_low_cnt + 1'b1;
    end
  end

  assign w_arb_set = bus_if.master_active & ~bus_if.sda_oe &
                     (((r_state == ST_BUSY) & w_scl_rise & ~bus_if.sda_in) | w_start | w_stop);

  always_ff @(posedge clk_sync or negedge reset_n) begin
    if (!reset_n) begin
      r_start_det     <= 1'b0;
      r_rep_start_det <= 1'b0;
      r_stop_det      <= 1'b0;
      r_bus_busy      <= 1'b0;
      r_bus_free      <= 1'b1;
      r_arb_lost      <= 1'b0;
      r_scl_timeout   <= 1'b0;
    end else begin
      r_start_det     <= w_start_nxt;
      r_rep_start_det <= w_rep_nxt;
      r_stop_det      <= w_stop_nxt;
      r_bus_busy      <= (w_state_nxt == ST_BUSY);
      r_bus_free      <= (w_state_nxt == ST_IDLE);
      if (w_arb_set) begin
        r_arb_lost <= 1'b1;
      end else if (bus_if.arb_lost_clr) begin
        r_arb_lost <= 1'b0;
      end
      if (w_tout_set) begin
        r_scl_timeout <= 1'b1;
      end else if (bus_if.timeout_clr) begin
        r_scl_timeout <= 1'b0;
      end
    end
  end

  assign bus_if.filter_tick   = r_tick;
  assign bus_if.start_det     = r_start_det;
  assign bus_if.rep_start_det = r_rep_start_det;
  assign bus_if.stop_det      = r_stop_det;
  assign bus_if.bus_busy      = r_bus_busy;
  assign bus_if.bus_free      = r_bus_free;
  assign bus_if.arb_lost      = r_arb_lost;
  assign bus_if.scl_timeout   = r_scl_timeout;
endmodule
